vga_timing_rx: RTL and testbench

VGA_TIMING_RX -- requirements
Module: vga_timing_rx

---
 rtl/vga_timing_rx.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_vga_timing_rx.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_rx.sv
// ---------------------------------------------------------------------------
// vga_timing_rx
//
// Receives a VGA-style raster (h_sync, v_sync, 12-bit RGB), measures the
// incoming timing, and once LOCK_FRAMES consecutive frames with the expected
// line length and line count have been seen, flags each active-area pixel
// with its (x, y) coordinate.
//
// Pipeline (rising edge of pixel_clk):
//   edge k   : h_sync / v_sync / rgb_in captured (syncs polarity-normalised)
//   edge k+1 : h_cnt / v_cnt / FSM updated from the captured sample
//   edge k+2 : pixel_data / pixel_x / pixel_y / pixel_valid / frame_start
//
// Ports:
//   pixel_clk    in   sole clock, rising edge
//   reset        in   asynchronous, active-high
//   h_sync       in   horizontal sync (polarity set by SYNC_ACTIVE_LOW)
//   v_sync       in   vertical sync   (polarity set by SYNC_ACTIVE_LOW)
//   rgb_in       in   12-bit 4:4:4 pixel colour
//   pixel_data   out  captured colour, 0 whenever pixel_valid is low
//   pixel_x      out  active-area column (holds outside the window)
//   pixel_y      out  active-area row    (holds outside the window)
//   pixel_valid  out  active-area pixel while locked
//   frame_start  out  one-cycle pulse alongside pixel (0,0) while locked
//   locked       out  high while the timing FSM is in LOCKED
//   sync_error   out  one-cycle pulse when a check fails while locked
// ---------------------------------------------------------------------------
module vga_timing_rx #(
    parameter int H_ACTIVE        = 640,
    parameter int H_SYNC          = 96,
    parameter int H_BACK          = 48,
    parameter int H_TOTAL         = 800,
    parameter int V_ACTIVE        = 480,
    parameter int V_SYNC          = 2,
    parameter int V_BACK          = 33,
    parameter int V_TOTAL         = 525,
    parameter int LOCK_FRAMES     = 2,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic        pixel_clk,
    input  logic        reset,
    input  logic        h_sync,
    input  logic        v_sync,
    input  logic [11:0] rgb_in,
    output logic [11:0] pixel_data,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        pixel_valid,
    output logic        frame_start,
    output logic        locked,
    output logic        sync_error
);

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    // XOR mask that turns the raw sync level into "1 = sync asserted".
    localparam logic SYNC_INV = (SYNC_ACTIVE_LOW != 0);

    // Active window bounds in counter units (start inclusive, end exclusive).
    localparam logic [10:0] H_OFS = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_LIM = 11'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [9:0]  V_OFS = 10'(V_SYNC + V_BACK);
    localparam logic [9:0]  V_LIM = 10'(V_SYNC + V_BACK + V_ACTIVE);

    // Expected lengths, one bit wider than the counters so that a saturated
    // counter plus one can never alias onto a legal total.
    localparam logic [11:0] H_TOTAL_W = 12'(H_TOTAL);
    localparam logic [10:0] V_TOTAL_W = 11'(V_TOTAL);

    localparam logic [10:0] H_SAT = 11'h7FF;
    localparam logic [9:0]  V_SAT = 10'h3FF;

    // Good-frame counter wide enough to hold LOCK_FRAMES itself.
    localparam int              GW          = $clog2(LOCK_FRAMES + 1);
    localparam logic [GW-1:0]   LOCK_TARGET = GW'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Input stage: one register for every input, syncs normalised so that
    // 1 always means "asserted". The previous-sample registers give the
    // leading-edge detect; under reset both hold the deasserted level, so a
    // sync that is already asserted at release is seen as a fresh edge.
    // -----------------------------------------------------------------------
    logic        hs_reg;
    logic        vs_reg;
    logic        hs_prev_reg;
    logic        vs_prev_reg;
    logic [11:0] rgb_reg;
    logic [11:0] rgb_dly_reg;

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            hs_reg      <= 1'b0;
            vs_reg      <= 1'b0;
            hs_prev_reg <= 1'b0;
            vs_prev_reg <= 1'b0;
            rgb_reg     <= 12'd0;
            rgb_dly_reg <= 12'd0;
        end else begin
            hs_reg      <= h_sync ^ SYNC_INV;
            vs_reg      <= v_sync ^ SYNC_INV;
            hs_prev_reg <= hs_reg;
            vs_prev_reg <= vs_reg;
            rgb_reg     <= rgb_in;
            // Extra delay so colour lines up with the counter-derived outputs.
            rgb_dly_reg <= rgb_reg;
        end
    end

    logic h_edge;
    logic v_edge;

    assign h_edge = hs_reg & ~hs_prev_reg;
    assign v_edge = vs_reg & ~vs_prev_reg;

    // -----------------------------------------------------------------------
    // Raster counters. h_cnt is the sample index since the last hsync
    // leading edge; v_cnt is the line index since the last vsync leading
    // edge. When both edges arrive together the vsync load takes priority,
    // which is the normal case at the top of a frame.
    // -----------------------------------------------------------------------
    logic [10:0] h_cnt_reg;
    logic [9:0]  v_cnt_reg;
    logic        h_seen_reg;
    logic        v_seen_reg;

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            h_cnt_reg  <= 11'd0;
            v_cnt_reg  <= 10'd0;
            h_seen_reg <= 1'b0;
            v_seen_reg <= 1'b0;
        end else begin
            if (h_edge) begin
                h_cnt_reg <= 11'd0;
            end else if (h_cnt_reg != H_SAT) begin
                h_cnt_reg <= h_cnt_reg + 11'd1;
            end

            if (v_edge) begin
                v_cnt_reg <= 10'd0;
            end else if (h_edge && (v_cnt_reg != V_SAT)) begin
                v_cnt_reg <= v_cnt_reg + 10'd1;
            end

            // The first edge of each kind after reset has no complete
            // line/frame behind it, so its measurement is not checked.
            if (h_edge) begin
                h_seen_reg <= 1'b1;
            end
            if (v_edge) begin
                v_seen_reg <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Timing checks, evaluated on the edge that closes a line or frame.
    // -----------------------------------------------------------------------
    logic [11:0] line_len;
    logic [10:0] frame_lines;
    logic        line_bad;
    logic        frame_checked;
    logic        frame_bad;
    logic        check_fail;

    assign line_len      = {1'b0, h_cnt_reg} + 12'd1;
    assign frame_lines   = {1'b0, v_cnt_reg} + 11'd1;
    assign line_bad      = h_edge & h_seen_reg & (line_len != H_TOTAL_W);
    assign frame_checked = v_edge & v_seen_reg;
    assign frame_bad     = frame_checked & (frame_lines != V_TOTAL_W);
    assign check_fail    = line_bad | frame_bad;

    // -----------------------------------------------------------------------
    // Lock FSM with registered locked / sync_error.
    // A line failure on the same edge as a passing frame check blocks the
    // lock, because the failure branch is taken ahead of the count branch.
    // -----------------------------------------------------------------------
    state_t        state_reg;
    logic [GW-1:0] good_cnt_reg;
    logic [GW-1:0] good_cnt_inc;
    logic          locked_reg;
    logic          sync_error_reg;

    assign good_cnt_inc = good_cnt_reg + GW'(1);

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            state_reg      <= UNLOCKED;
            good_cnt_reg   <= '0;
            locked_reg     <= 1'b0;
            sync_error_reg <= 1'b0;
        end else begin
            sync_error_reg <= 1'b0;
            case (state_reg)
                UNLOCKED: begin
                    locked_reg <= 1'b0;
                    if (v_edge) begin
                        state_reg    <= ACQUIRE;
                        good_cnt_reg <= '0;
                    end
                end

                ACQUIRE: begin
                    if (check_fail) begin
                        good_cnt_reg <= '0;
                    end else if (frame_checked) begin
                        good_cnt_reg <= good_cnt_inc;
                        if (good_cnt_inc == LOCK_TARGET) begin
                            state_reg  <= LOCKED;
                            locked_reg <= 1'b1;
                        end
                    end
                end

                LOCKED: begin
                    if (check_fail) begin
                        state_reg      <= ACQUIRE;
                        good_cnt_reg   <= '0;
                        locked_reg     <= 1'b0;
                        sync_error_reg <= 1'b1;
                    end
                end

                default: begin
                    state_reg    <= UNLOCKED;
                    good_cnt_reg <= '0;
                    locked_reg   <= 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output stage. The counters here describe the sample captured one edge
    // earlier, and locked_reg already reflects any FSM update made for that
    // same sample, so validity and colour stay aligned.
    // -----------------------------------------------------------------------
    logic        in_window;
    logic        valid_next;
    logic        origin;
    logic [11:0] pixel_data_reg;
    logic [9:0]  pixel_x_reg;
    logic [9:0]  pixel_y_reg;
    logic        pixel_valid_reg;
    logic        frame_start_reg;

    assign in_window  = (h_cnt_reg >= H_OFS) && (h_cnt_reg < H_LIM) &&
                        (v_cnt_reg >= V_OFS) && (v_cnt_reg < V_LIM);
    assign valid_next = in_window & locked_reg;
    assign origin     = (h_cnt_reg == H_OFS) && (v_cnt_reg == V_OFS);

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            pixel_data_reg  <= 12'd0;
            pixel_x_reg     <= 10'd0;
            pixel_y_reg     <= 10'd0;
            pixel_valid_reg <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            pixel_valid_reg <= valid_next;
            pixel_data_reg  <= valid_next ? rgb_dly_reg : 12'd0;
            frame_start_reg <= valid_next & origin;
            // Coordinates track the window even before lock and freeze
            // outside it, so they show the last active pixel.
            if (in_window) begin
                pixel_x_reg <= 10'(h_cnt_reg - H_OFS);
                pixel_y_reg <= v_cnt_reg - V_OFS;
            end
        end
    end

    assign pixel_data  = pixel_data_reg;
    assign pixel_x     = pixel_x_reg;
    assign pixel_y     = pixel_y_reg;
    assign pixel_valid = pixel_valid_reg;
    assign frame_start = frame_start_reg;
    assign locked      = locked_reg;
    assign sync_error  = sync_error_reg;

endmodule

// File: tb/tb_vga_timing_rx.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_rx
//
// Drives a scaled-down raster (28 clocks x 18 lines, 16x10 active) into two
// receivers: one expecting active-low syncs, one expecting active-high syncs
// fed the inverted waveform. A frame-level reference model decides, from the
// line lengths and line counts it generated, when lock should be held and
// which samples are visible pixels; expectations go into queues that a
// separate monitor drains against the DUT outputs.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_timing_rx;

    localparam int HA = 16;
    localparam int HS = 4;
    localparam int HB = 3;
    localparam int HT = 28;
    localparam int VA = 10;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int VT = 18;
    localparam int LF = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        hs_p;
    logic        vs_p;
    logic        hs_n;
    logic        vs_n;
    logic [11:0] rgb;

    logic [11:0] a_data,  b_data;
    logic [9:0]  a_x,     b_x;
    logic [9:0]  a_y,     b_y;
    logic        a_valid, b_valid;
    logic        a_fs,    b_fs;
    logic        a_lock,  b_lock;
    logic        a_err,   b_err;

    assign hs_n = ~hs_p;
    assign vs_n = ~vs_p;

    always #5 clk = ~clk;

    vga_timing_rx #(
        .H_ACTIVE(HA), .H_SYNC(HS), .H_BACK(HB), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC(VS), .V_BACK(VB), .V_TOTAL(VT),
        .LOCK_FRAMES(LF), .SYNC_ACTIVE_LOW(1)
    ) dut_low (
        .pixel_clk(clk), .reset(reset), .h_sync(hs_n), .v_sync(vs_n),
        .rgb_in(rgb), .pixel_data(a_data), .pixel_x(a_x), .pixel_y(a_y),
        .pixel_valid(a_valid), .frame_start(a_fs), .locked(a_lock),
        .sync_error(a_err)
    );

    vga_timing_rx #(
        .H_ACTIVE(HA), .H_SYNC(HS), .H_BACK(HB), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC(VS), .V_BACK(VB), .V_TOTAL(VT),
        .LOCK_FRAMES(LF), .SYNC_ACTIVE_LOW(0)
    ) dut_high (
        .pixel_clk(clk), .reset(reset), .h_sync(hs_p), .v_sync(vs_p),
        .rgb_in(rgb), .pixel_data(b_data), .pixel_x(b_x), .pixel_y(b_y),
        .pixel_valid(b_valid), .frame_start(b_fs), .locked(b_lock),
        .sync_error(b_err)
    );

    typedef struct packed {
        logic [11:0] d;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        fs;
    } pix_t;

    typedef struct packed {
        logic lk;
        logic se;
    } ctl_t;

    pix_t pix_q[$];
    ctl_t ctl_q[$];

    int vectors = 0;
    int errors  = 0;

    // Reference model state: 0 = unlocked, 1 = acquiring, 2 = locked.
    int m_state;
    int m_good;
    int last_line_len;     // 0 = no complete line observed since reset
    int last_frame_lines;  // 0 = no complete frame observed since reset

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        chk({name, ".pixel_data"},  32'(a_data),  32'd0);
        chk({name, ".pixel_x"},     32'(a_x),     32'd0);
        chk({name, ".pixel_y"},     32'(a_y),     32'd0);
        chk({name, ".pixel_valid"}, 32'(a_valid), 32'd0);
        chk({name, ".frame_start"}, 32'(a_fs),    32'd0);
        chk({name, ".locked"},      32'(a_lock),  32'd0);
        chk({name, ".sync_error"},  32'(a_err),   32'd0);
    endtask

    // One raster sample at line l, position p of a line of length len in a
    // frame of nl lines. Sync leading edges coincide with p == 0.
    task automatic model_sample(input int l, input int p, input int len, input int nl);
        bit   line_fail;
        bit   frame_chk;
        bit   frame_fail;
        bit   se;
        ctl_t c;
        pix_t e;
        se = 1'b0;
        if (reset) begin
            m_state          = 0;
            m_good           = 0;
            last_line_len    = 0;
            last_frame_lines = 0;
            c.lk = 1'b0;
            c.se = 1'b0;
            ctl_q.push_back(c);
            return;
        end
        if (p == 0) begin
            line_fail  = (last_line_len != 0) && (last_line_len != HT);
            frame_chk  = (l == 0) && (last_frame_lines != 0);
            frame_fail = frame_chk && (last_frame_lines != VT);
            case (m_state)
                0: if (l == 0) begin
                    m_state = 1;
                    m_good  = 0;
                end
                1: if (line_fail || frame_fail) begin
                    m_good = 0;
                end else if (frame_chk) begin
                    m_good++;
                    if (m_good == LF) m_state = 2;
                end
                default: if (line_fail || frame_fail) begin
                    se      = 1'b1;
                    m_state = 1;
                    m_good  = 0;
                end
            endcase
        end
        if (p == len - 1) last_line_len = len;
        if ((p == len - 1) && (l == nl - 1)) last_frame_lines = nl;
        c.lk = (m_state == 2);
        c.se = se;
        ctl_q.push_back(c);
        if ((m_state == 2) && (p >= HS + HB) && (p < HS + HB + HA) &&
            (l >= VS + VB) && (l < VS + VB + VA)) begin
            e.d  = rgb;
            e.x  = 10'(p - (HS + HB));
            e.y  = 10'(l - (VS + VB));
            e.fs = (p == HS + HB) && (l == VS + VB);
            pix_q.push_back(e);
        end
    endtask

    // nl lines; line sl (if >= 0) is one clock short; reset is asserted in
    // the middle of active line rl (if >= 0) and held until the next frame.
    task automatic drive_frame(input int f, input int nl, input int sl, input int rl);
        int len;
        for (int l = 0; l < nl; l++) begin
            len = (l == sl) ? HT - 1 : HT;
            for (int p = 0; p < len; p++) begin
                @(negedge clk);
                if (reset && (l == 0) && (p == 0)) reset = 1'b0;
                hs_p = (p < HS);
                vs_p = (l < VS);
                if ((l == VS + VB) && (p == HS + HB)) rgb = 12'hABC;
                else rgb = 12'($urandom());
                model_sample(l, p, len, nl);
                if ((l == rl) && (p == HS + HB + 5)) begin
                    @(posedge clk);
                    #2;
                    reset = 1'b1;
                    #1;
                    check_all_zero("reset_mid_line");
                    pix_q.delete();
                    ctl_q.delete();
                end
            end
        end
        $display("frame %0d: lines=%0d short_line=%0d reset_line=%0d model_state=%0d queued_pixels=%0d",
                 f, nl, sl, rl, m_state, pix_q.size());
    endtask

    // Monitor: one look per cycle, 1 ns after the rising edge.
    initial begin
        ctl_t c;
        pix_t e;
        forever begin
            @(posedge clk);
            #1;
            vectors++;
            if ({a_data, a_x, a_y, a_valid, a_fs, a_lock, a_err} !==
                {b_data, b_x, b_y, b_valid, b_fs, b_lock, b_err}) begin
                errors++;
                $display("FAIL polarity t=%0t low=%h/%0d/%0d/%b%b%b%b high=%h/%0d/%0d/%b%b%b%b",
                         $time, a_data, a_x, a_y, a_valid, a_fs, a_lock, a_err,
                         b_data, b_x, b_y, b_valid, b_fs, b_lock, b_err);
            end
            // Lock status lags its sample by one more edge than the sample's
            // own capture, hence the one-entry slack in the queue.
            if (ctl_q.size() >= 2) begin
                c = ctl_q.pop_front();
                vectors++;
                if ((a_lock !== c.lk) || (a_err !== c.se)) begin
                    errors++;
                    $display("FAIL lock_ctl t=%0t locked=%b sync_error=%b expected locked=%b sync_error=%b",
                             $time, a_lock, a_err, c.lk, c.se);
                end
            end
            vectors++;
            if (a_valid === 1'b1) begin
                if (pix_q.size() == 0) begin
                    errors++;
                    $display("FAIL pixel_unexpected t=%0t data=%h x=%0d y=%0d expected no pixel",
                             $time, a_data, a_x, a_y);
                end else begin
                    e = pix_q.pop_front();
                    if ((a_data !== e.d) || (a_x !== e.x) || (a_y !== e.y) || (a_fs !== e.fs)) begin
                        errors++;
                        $display("FAIL pixel t=%0t got data=%h x=%0d y=%0d fs=%b expected data=%h x=%0d y=%0d fs=%b",
                                 $time, a_data, a_x, a_y, a_fs, e.d, e.x, e.y, e.fs);
                    end
                end
            end else if ((a_data !== 12'd0) || (a_fs !== 1'b0) || (a_valid !== 1'b0)) begin
                errors++;
                $display("FAIL idle_outputs t=%0t valid=%b data=%h fs=%b expected valid=0 data=0 fs=0",
                         $time, a_valid, a_data, a_fs);
            end
        end
    end

    initial begin
        int r;
        int fno;
        reset = 1'b1;
        hs_p  = 1'b0;
        vs_p  = 1'b0;
        rgb   = 12'd0;
        m_state          = 0;
        m_good           = 0;
        last_line_len    = 0;
        last_frame_lines = 0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        check_all_zero("reset_state");

        // Acquire and lock, then hold lock for a frame.
        drive_frame(0, VT, -1, -1);
        drive_frame(1, VT, -1, -1);
        drive_frame(2, VT, -1, -1);
        drive_frame(3, VT, -1, -1);
        // Short line while locked, recovery.
        drive_frame(4, VT, int'($urandom_range(0, VT - 1)), -1);
        drive_frame(5, VT, -1, -1);
        drive_frame(6, VT, -1, -1);
        // Short frame while locked.
        drive_frame(7, VT - 1, -1, -1);
        drive_frame(8, VT, -1, -1);
        // Short last line: the failure lands on the would-be lock edge.
        drive_frame(9, VT, VT - 1, -1);
        drive_frame(10, VT, -1, -1);
        drive_frame(11, VT, -1, -1);
        // Reset in the middle of an active line while locked.
        drive_frame(12, VT, -1, VS + VB + 2);
        drive_frame(13, VT, -1, -1);
        drive_frame(14, VT, -1, -1);
        drive_frame(15, VT, -1, -1);
        drive_frame(16, VT, -1, -1);
        // Randomised mix of good and faulty frames.
        fno = 17;
        for (int i = 0; i < 8; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6)      drive_frame(fno, VT, -1, -1);
            else if (r < 8) drive_frame(fno, VT, int'($urandom_range(0, VT - 1)), -1);
            else            drive_frame(fno, VT - 1, -1, -1);
            fno++;
        end
        drive_frame(fno, VT, -1, -1);
        drive_frame(fno + 1, VT, -1, -1);
        drive_frame(fno + 2, VT, -1, -1);

        repeat (4) @(negedge clk);
        chk("pixels_outstanding", 32'(pix_q.size()), 32'd0);
        chk("final_locked", 32'(a_lock), 32'(m_state == 2));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
